sr_cmd_sequencer: RTL and testbench

Upstream driver for a bank of WIDTH clocked SR flip-flops. The flip-flops update on posedge clk: 00 hold, 01 clear, 10 set, 11 forbidden/X.
- Accepts set/clear/toggle/hold commands over a valid/ready handshake.
- Converts each command into legal S/R excitation pulses, so S=R=1 is never driven.
- Reads back the bank's Q to verify the result, with bounded retry and a sticky error.
- This generalises SR-to-T/D conversion into a verified command path.

---
 rtl/sr_seq_pkg.sv | 49 ++++
 rtl/sr_cmd_sequencer.sv | 114 +++++++++++
 tb/tb_sr_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_seq_pkg.sv
// Shared encodings and pure helper functions for the SR command sequencer.
// Functions work at the maximum supported width; callers zero-extend and truncate.
package sr_seq_pkg;

    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDrive = 2'b01,
        StCheck = 2'b10,
        StError = 2'b11
    } state_e;

    typedef struct packed {
        logic [MaxWidth-1:0] s;
        logic [MaxWidth-1:0] r;
    } excite_t;

    function automatic logic [MaxWidth-1:0] f_expected(input op_e                 op,
                                                       input logic [MaxWidth-1:0] q,
                                                       input logic [MaxWidth-1:0] mask);
        logic [MaxWidth-1:0] res;
        unique case (op)
            OP_CLEAR:  res = q & ~mask;
            OP_SET:    res = q | mask;
            OP_TOGGLE: res = q ^ mask;
            default:   res = q;
        endcase
        return res;
    endfunction

    // Only bits that must change get a pulse, so S and R are never both set.
    function automatic excite_t f_excite(input logic [MaxWidth-1:0] exp_v,
                                         input logic [MaxWidth-1:0] q,
                                         input logic [MaxWidth-1:0] mask);
        excite_t ex;
        ex.s = mask & exp_v & ~q;
        ex.r = mask & ~exp_v & q;
        return ex;
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer.sv
// Drives a bank of SR flip-flops from set/clear/toggle/hold commands, verifies the
// resulting Q, retries a bounded number of times and latches a sticky error.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic [2:0]       retry_q, retry_d;

    logic [WIDTH-1:0] acc_exp;
    excite_t          acc_ex;
    excite_t          chk_ex;
    logic             chk_match;

    assign acc_exp = WIDTH'(f_expected(op_e'(req_op), MaxWidth'(q_in), MaxWidth'(req_mask)));
    assign acc_ex  = f_excite(MaxWidth'(acc_exp), MaxWidth'(q_in), MaxWidth'(req_mask));
    // Retries re-excite against the live Q, so only still-wrong bits are pulsed.
    assign chk_ex    = f_excite(MaxWidth'(exp_q), MaxWidth'(q_in), MaxWidth'(mask_q));
    assign chk_match = ((q_in ^ exp_q) & mask_q) == '0;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        s_d     = '0;
        r_d     = '0;
        done_d  = 1'b0;
        retry_d = retry_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    exp_d   = acc_exp;
                    mask_d  = req_mask;
                    s_d     = WIDTH'(acc_ex.s);
                    r_d     = WIDTH'(acc_ex.r);
                    retry_d = 3'd0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (chk_match) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d = retry_q + 3'd1;
                    s_d     = WIDTH'(chk_ex.s);
                    r_d     = WIDTH'(chk_ex.r);
                    state_d = StDrive;
                end else begin
                    state_d = StError;
                end
            end
            StError: begin
                if (err_clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            exp_q   <= '0;
            mask_q  <= '0;
            s_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            retry_q <= 3'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            retry_q <= retry_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q == StDrive) || (state_q == StCheck);
    assign err       = (state_q == StError);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Self-checking bench: SR flip-flop bank as load, directed steps plus random commands
// compared against a per-bit behavioural model of the command rules.
module tb_sr_cmd_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_mask = '0;
    logic [W-1:0] q_in;
    logic [W-1:0] s_out;
    logic [W-1:0] r_out;
    logic         done;
    logic         err;
    logic         err_clr = 1'b0;
    logic         busy;

    logic [W-1:0] bank = '0;
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         fault_en = 1'b0;
    logic [W-1:0] model_q = '0;

    int checks = 0;
    int failures = 0;

    sr_cmd_sequencer #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .q_in      (q_in),
        .s_out     (s_out),
        .r_out     (r_out),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // SR bank load: 00 hold, 01 clear, 10 set, 11 unknown.
    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else begin
            for (int i = 0; i < W; i++) begin
                case ({s_out[i], r_out[i]})
                    2'b01:   bank[i] <= 1'b0;
                    2'b10:   bank[i] <= 1'b1;
                    2'b11:   bank[i] <= 1'bx;
                    default: bank[i] <= bank[i];
                endcase
            end
        end
    end

    // Stuck-at-0 on bit 0 when fault injection is enabled.
    assign q_in = fault_en ? (bank & ~W'(1)) : bank;

    always @(negedge clk) begin
        checks++;
        assert ((s_out & r_out) === '0) else begin
            failures++;
            $error("FAIL s_and_r: got %b required 0", s_out & r_out);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: got %b required %b", tag, obs, req);
        end
    endtask

    task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: got %b required %b", tag, obs, req);
        end
    endtask

    function automatic logic [W-1:0] model_exp(input logic [1:0] op, input logic [W-1:0] q,
                                               input logic [W-1:0] mask);
        logic [W-1:0] e;
        for (int i = 0; i < W; i++) begin
            if (!mask[i])        e[i] = q[i];
            else if (op == 2'd1) e[i] = 1'b0;
            else if (op == 2'd2) e[i] = 1'b1;
            else if (op == 2'd3) e[i] = ~q[i];
            else                 e[i] = q[i];
        end
        return e;
    endfunction

    task automatic preload(input logic [W-1:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(posedge clk);
        #1;
        load_en  = 1'b0;
        model_q  = v;
    endtask

    // One full command: accept, DRIVE, CHECK/done. Returns in the done cycle.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] mask, input bit junk);
        logic [W-1:0] e, s, r;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("ready_wait", req_ready, 1'b1);
        e = model_exp(op, model_q, mask);
        for (int i = 0; i < W; i++) begin
            s[i] = mask[i] && (e[i] != model_q[i]) && e[i];
            r[i] = mask[i] && (e[i] != model_q[i]) && !e[i];
        end
        req_valid = 1'b1;
        req_op    = op;
        req_mask  = mask;
        @(posedge clk);
        #1;
        chkv("acc_s", s_out, s);
        chkv("acc_r", r_out, r);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_ready", req_ready, 1'b0);
        if (junk) begin
            req_op   = 2'($urandom);
            req_mask = W'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chkv("drv_s", s_out, '0);
        chkv("drv_r", r_out, '0);
        chkv("drv_q", q_in, e);
        chk1("drv_done", done, 1'b0);
        if (junk) begin
            req_op   = 2'($urandom);
            req_mask = W'($urandom);
        end
        @(posedge clk);
        #1;
        chk1("done", done, 1'b1);
        chk1("done_ready", req_ready, 1'b1);
        chk1("done_busy", busy, 1'b0);
        chk1("done_err", err, 1'b0);
        chkv("done_q", q_in, e);
        req_valid = 1'b0;
        model_q   = e;
    endtask

    initial begin
        int pulses;
        #2;
        chkv("rst_s", s_out, '0);
        chkv("rst_r", r_out, '0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic SET, then TOGGLE, then back-to-back CLEAR.
        preload(4'b0000);
        issue(2'd2, 4'b0101, 1'b0);
        chkv("t1_q", q_in, 4'b0101);
        issue(2'd3, 4'b1111, 1'b0);
        chkv("t2_q", q_in, 4'b1010);
        issue(2'd1, 4'b0011, 1'b0);
        chkv("t2_clr_q", q_in, 4'b1000);

        // No-pulse commands.
        issue(2'd0, 4'b1111, 1'b0);
        issue(2'd2, 4'b0000, 1'b0);
        chkv("t3_q", q_in, 4'b1000);

        // err_clr outside ERROR does nothing.
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk1("clr_idle_ready", req_ready, 1'b1);
        chk1("clr_idle_err", err, 1'b0);

        // Requests held high across DRIVE/CHECK with changing op.
        issue(2'd2, 4'b0011, 1'b1);
        issue(2'd3, 4'b0110, 1'b1);
        issue(2'd1, 4'b1111, 1'b0);

        // Stuck bit: three drive pulses then ERROR.
        preload(4'b0000);
        fault_en  = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_mask  = 4'b0001;
        pulses    = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (s_out == 4'b0001) pulses++;
            chk1("stuck_nodone", done, 1'b0);
            @(posedge clk);
            #1;
        end
        checks++;
        assert (pulses == 3) else begin
            failures++;
            $error("FAIL stuck_pulses: got %0d required 3", pulses);
        end
        chk1("stuck_err", err, 1'b1);
        chk1("stuck_ready", req_ready, 1'b0);
        chk1("stuck_busy", busy, 1'b0);
        req_valid = 1'b1;
        req_mask  = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk1("err_ignore", err, 1'b1);
        chkv("err_s", s_out, '0);
        req_valid = 1'b0;
        err_clr   = 1'b1;
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        fault_en  = 1'b0;
        chk1("errclr_err", err, 1'b0);
        chk1("errclr_ready", req_ready, 1'b1);

        // Reset during DRIVE.
        preload(4'b0000);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_mask  = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chkv("mid_s", s_out, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chkv("rst_mid_s", s_out, '0);
        chkv("rst_mid_r", r_out, '0);
        chk1("rst_mid_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk1("rst_nodone", done, 1'b0);
            chkv("rst_q", q_in, 4'b0000);
        end

        // Random commands against the model.
        preload(W'($urandom));
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), W'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
